// File: rtl/key_scan_pkg.sv
// Shared types and width helpers for the key scan/debounce controller.
package key_scan_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } key_state_t;

  // Sample counter covers CONFIRM up to 15.
  localparam int unsigned SC_W = 4;

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_fsm.sv
// Per-key confirm/release state machine with hold-to-repeat; advances on tick only.
module key_fsm
  import key_scan_pkg::*;
#(
  parameter int unsigned CONFIRM      = 2,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic s,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int unsigned HC_W = cnt_w(REPEAT_DELAY);
  localparam int unsigned RC_W = cnt_w(REPEAT_RATE);

  localparam logic [SC_W-1:0] SC_ONE     = SC_W'(1);
  localparam logic [SC_W-1:0] SC_CONFIRM = SC_W'(CONFIRM);
  localparam logic [HC_W-1:0] HC_ONE     = HC_W'(1);
  localparam logic [HC_W-1:0] HC_DELAY   = HC_W'(REPEAT_DELAY);
  localparam logic [RC_W-1:0] RC_ONE     = RC_W'(1);
  localparam logic [RC_W-1:0] RC_RATE    = RC_W'(REPEAT_RATE);

  key_state_t      state;
  logic [SC_W-1:0] sc;
  logic [HC_W-1:0] hc;
  logic [RC_W-1:0] rc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sc    <= '0;
      hc    <= '0;
      rc    <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      rpt   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      rpt   <= 1'b0;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (s) begin
              if (CONFIRM == 1) begin
                state <= HELD;
                hc    <= '0;
                rc    <= '0;
                press <= 1'b1;
                level <= 1'b1;
              end else begin
                state <= PRESS_CHK;
                sc    <= SC_ONE;
              end
            end
          end
          PRESS_CHK: begin
            if (!s) begin
              state <= IDLE;
              sc    <= '0;
            end else if (sc + SC_ONE == SC_CONFIRM) begin
              state <= HELD;
              sc    <= '0;
              hc    <= '0;
              rc    <= '0;
              press <= 1'b1;
              level <= 1'b1;
            end else begin
              sc <= sc + SC_ONE;
            end
          end
          HELD: begin
            if (!s) begin
              if (CONFIRM == 1) begin
                state <= IDLE;
                rel   <= 1'b1;
                level <= 1'b0;
              end else begin
                state <= REL_CHK;
                sc    <= SC_ONE;
              end
            end else if (hc != HC_DELAY) begin
              hc <= hc + HC_ONE;
              if (hc + HC_ONE == HC_DELAY) begin
                rpt <= 1'b1;
                rc  <= '0;
              end
            end else if (rc + RC_ONE == RC_RATE) begin
              rpt <= 1'b1;
              rc  <= '0;
            end else begin
              rc <= rc + RC_ONE;
            end
          end
          REL_CHK: begin
            // A bounce back to pressed resumes the hold; hc/rc are left intact.
            if (s) begin
              state <= HELD;
              sc    <= '0;
            end else if (sc + SC_ONE == SC_CONFIRM) begin
              state <= IDLE;
              sc    <= '0;
              rel   <= 1'b1;
              level <= 1'b0;
            end else begin
              sc <= sc + SC_ONE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// Push-button debounce/event controller: input synchronizers, shared sample tick, one FSM per key.
module key_scan_ctrl
  import key_scan_pkg::*;
#(
  parameter int unsigned N_KEYS       = 4,
  parameter int unsigned TICK_DIV     = 1000000,
  parameter int unsigned CONFIRM      = 2,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keys_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              tick
);

  localparam int unsigned         TICK_W    = cnt_w(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(TICK_DIV - 2);

  logic [TICK_W-1:0] tick_cnt;
  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;

  // tick is registered one count early so it is high exactly while tick_cnt == TICK_LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      sync1    <= keys_in;
      sync2    <= sync1;
      tick     <= (tick_cnt == TICK_PRE);
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_fsm #(
      .CONFIRM     (CONFIRM),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_fsm (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .s    (sync2[i]),
      .level(key_level[i]),
      .press(key_press[i]),
      .rel  (key_release[i]),
      .rpt  (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl with TICK_DIV=4, CONFIRM=2, REPEAT_DELAY=5, REPEAT_RATE=2.
module tb_key_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keys_in;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_repeat;
  logic       tick;

  int n_checks = 0;
  int n_errors = 0;

  // cyc = clock edges since the last reset edge; tick is expected at cyc % 4 == 3,
  // and every event pulse lands at cyc % 4 == 0.
  int cyc = 0;
  int press_cnt[4], press_cyc[4], rel_cnt[4], rel_cyc[4];
  int rpt_cnt[4], rpt_first[4], rpt_last[4];
  int lvl_seen[4];
  int bad_phase = 0;
  int overlap   = 0;
  logic [3:0] idle_act;

  key_scan_ctrl #(
    .N_KEYS      (4),
    .TICK_DIV    (4),
    .CONFIRM     (2),
    .REPEAT_DELAY(5),
    .REPEAT_RATE (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keys_in    (keys_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, $signed(got), $signed(exp), cyc);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (key_press[i]) begin
        press_cnt[i]++;
        press_cyc[i] = cyc;
        if (cyc % 4 != 0) bad_phase++;
        if (key_repeat[i]) overlap++;
      end
      if (key_release[i]) begin
        rel_cnt[i]++;
        rel_cyc[i] = cyc;
        if (cyc % 4 != 0) bad_phase++;
      end
      if (key_repeat[i]) begin
        rpt_cnt[i]++;
        if (rpt_first[i] < 0) rpt_first[i] = cyc;
        rpt_last[i] = cyc;
        if (cyc % 4 != 0) bad_phase++;
      end
      if (key_level[i]) lvl_seen[i] = 1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0; press_cyc[i] = -1; rel_cnt[i] = 0; rel_cyc[i] = -1;
      rpt_cnt[i] = 0; rpt_first[i] = -1; rpt_last[i] = -1; lvl_seen[i] = 0;
    end
    rst     = 1'b1;
    keys_in = '0;
    repeat (3) cycle();
    rst = 1'b0;
    cyc = 0;

    // Reset state and idle tick cadence
    check("rst_level", key_level, 0);
    check("rst_tick", tick, 0);
    check("rst_pulses", key_press | key_release | key_repeat, 0);
    idle_act = '0;
    for (int n = 1; n <= 40; n++) begin
      cycle();
      check("idle_tick", tick, (cyc % 4 == 3) ? 1 : 0);
      idle_act = idle_act | key_level | key_press | key_release | key_repeat;
    end
    check("idle_outputs", idle_act, 0);

    // Key0 press, hold-to-repeat, release
    keys_in[0] = 1'b1;
    wait_until(47);
    check("k0_level_before", key_level[0], 0);
    wait_until(48);
    check("k0_press", key_press[0], 1);
    check("k0_level_rise", key_level[0], 1);
    cycle();
    check("k0_press_width", key_press[0], 0);
    wait_until(96);
    keys_in[0] = 1'b0;
    wait_until(103);
    check("k0_level_relchk", key_level[0], 1);
    wait_until(104);
    check("k0_release", key_release[0], 1);
    check("k0_level_fall", key_level[0], 0);
    check("k0_press_cnt", press_cnt[0], 1);
    check("k0_rpt_cnt", rpt_cnt[0], 4);
    check("k0_rpt_first", rpt_first[0], 68);
    check("k0_rpt_last", rpt_last[0], 92);

    // Key1 glitch spanning exactly one tick
    wait_until(108);
    keys_in[1] = 1'b1;
    wait_until(111);
    keys_in[1] = 1'b0;

    // Key2 and key3 together; key2 bounces during release confirmation
    wait_until(120);
    check("k1_press_cnt", press_cnt[1], 0);
    check("k1_rel_cnt", rel_cnt[1], 0);
    check("k1_level_seen", lvl_seen[1], 0);
    keys_in[3:2] = 2'b11;
    wait_until(128);
    check("k23_press", key_press, 4'b1100);
    wait_until(136);
    keys_in[2] = 1'b0;
    wait_until(140);
    keys_in[2] = 1'b1;
    wait_until(141);
    check("k2_level_bounce", key_level[2], 1);
    wait_until(160);
    check("k2_press_cyc", press_cyc[2], 128);
    check("k3_press_cyc", press_cyc[3], 128);
    check("k2_rel_cnt", rel_cnt[2], 0);
    check("k2_level_held", key_level[2], 1);
    check("k3_rpt_first", rpt_first[3], 148);
    check("k2_rpt_first_hc_kept", rpt_first[2], 156);
    check("k0_rpt_after_rel", rpt_cnt[0], 4);

    // Reset while keys 0, 2, 3 are held
    keys_in[0] = 1'b1;
    wait_until(168);
    check("k0_repress", key_press[0], 1);
    check("k0_press_cnt2", press_cnt[0], 2);
    wait_until(172);
    rst = 1'b1;
    cycle();
    check("mid_rst_level", key_level, 0);
    check("mid_rst_release", key_release, 0);
    check("mid_rst_pulses", key_press | key_repeat, 0);
    check("mid_rst_tick", tick, 0);
    cycle();
    rst = 1'b0;
    cyc = 0;
    wait_until(3);
    check("post_rst_first_tick", tick, 1);
    wait_until(7);
    check("post_rst_level_pending", key_level, 0);
    wait_until(8);
    check("post_rst_press", key_press, 4'b1101);
    check("post_rst_level", key_level, 4'b1101);
    check("post_rst_k0_press_cyc", press_cyc[0], 8);
    wait_until(12);
    check("k0_rel_total", rel_cnt[0], 1);
    check("k2_rel_total", rel_cnt[2], 0);
    check("k3_rel_total", rel_cnt[3], 0);
    check("pulse_phase", bad_phase, 0);
    check("press_rpt_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
